// File: rtl/risc_pkg.sv
// risc_pkg: shared call/return controller state encoding and datapath defaults.
package risc_pkg;
  localparam int RISC_DATA_W = 32;
  localparam int RISC_DEPTH  = 64;
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_POP_REQ  = 2'd1;
  localparam logic [1:0] S_POP_WAIT = 2'd2;
endpackage

// File: rtl/Stack.sv
// Stack: return-address LIFO; data_out is valid the cycle after read.
module Stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  // One extra pointer bit so a completely full stack does not alias empty
  logic [AW:0]       r_ptr;
  logic [AW:0]       w_top;
  assign w_top = r_ptr - 1'b1;
  always_ff @(posedge clk) begin
    if (write) begin
      r_mem[r_ptr[AW-1:0]] <= data_in;
      r_ptr                <= r_ptr + 1'b1;
    end else if (read) begin
      data_out <= r_mem[w_top[AW-1:0]];
      r_ptr    <= w_top;
    end
  end
endmodule

// File: rtl/call_return_ctrl.sv
// call_return_ctrl: turns CALL/RET requests into stack push/pop strobes and PC redirects,
// tracking depth and stalling the control unit while a pop is in flight.
module call_return_ctrl
  import risc_pkg::*;
#(
  parameter  int DATA_W = RISC_DATA_W,
  parameter  int DEPTH  = RISC_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              call,
  input  logic              ret,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] target,
  output logic              busy,
  output logic              next_pc_valid,
  output logic [DATA_W-1:0] next_pc,
  output logic              stack_write,
  output logic              stack_read,
  output logic [DATA_W-1:0] stack_data_in,
  input  logic [DATA_W-1:0] stack_data_out,
  output logic [CNT_W-1:0]  depth,
  output logic              overflow,
  output logic              underflow
);
  logic [1:0]        r_state;
  logic              r_busy, r_npv, r_write, r_read, r_ovf, r_unf;
  logic [DATA_W-1:0] r_next_pc, r_sdi;
  logic [CNT_W-1:0]  r_depth;
  logic              w_full, w_empty;
  assign w_full  = r_depth == CNT_W'(DEPTH);
  assign w_empty = r_depth == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_npv     <= 1'b0;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_next_pc <= '0;
      r_sdi     <= '0;
      r_depth   <= '0;
    end else begin
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_npv   <= 1'b0;
      if (r_state == S_POP_REQ) begin
        r_state <= S_POP_WAIT;
      end else if (r_state == S_POP_WAIT) begin
        // Stack word popped by the previous read strobe is on data_out now
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_next_pc <= stack_data_out;
        r_npv     <= 1'b1;
      end else if (r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end else if (call) begin
        if (w_full) r_ovf <= 1'b1;
        else begin
          r_write   <= 1'b1;
          r_sdi     <= pc + DATA_W'(1);
          r_next_pc <= target;
          r_npv     <= 1'b1;
          r_depth   <= r_depth + CNT_W'(1);
        end
      end else if (ret) begin
        if (w_empty) r_unf <= 1'b1;
        else begin
          r_read  <= 1'b1;
          r_busy  <= 1'b1;
          r_depth <= r_depth - CNT_W'(1);
          r_state <= S_POP_REQ;
        end
      end
    end
  end
  assign busy          = r_busy;
  assign next_pc_valid = r_npv;
  assign next_pc       = r_next_pc;
  assign stack_write   = r_write;
  assign stack_read    = r_read;
  assign stack_data_in = r_sdi;
  assign depth         = r_depth;
  assign overflow      = r_ovf;
  assign underflow     = r_unf;
endmodule

// File: tb/tb_call_return_ctrl.sv
// tb_call_return_ctrl: scoreboard bench for call_return_ctrl driving a real Stack.
module tb_call_return_ctrl;
  localparam int DW = 32;
  localparam int DP = 64;
  localparam int CW = $clog2(DP + 1);
  typedef struct {
    logic [DW-1:0] v;
    int            c;
  } exp_t;
  logic          clk = 1'b0, rst_n = 1'b0, call = 1'b0, ret = 1'b0;
  logic [DW-1:0] pc = '0, target = '0;
  logic          busy, next_pc_valid, stack_write, stack_read, overflow, underflow;
  logic [DW-1:0] next_pc, stack_data_in, stack_data_out;
  logic [CW-1:0] depth;
  exp_t          sb[$];
  int            vec = 0, errs = 0, cyc = 0;
  call_return_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .call(call), .ret(ret), .pc(pc), .target(target),
    .busy(busy), .next_pc_valid(next_pc_valid), .next_pc(next_pc),
    .stack_write(stack_write), .stack_read(stack_read), .stack_data_in(stack_data_in),
    .stack_data_out(stack_data_out), .depth(depth), .overflow(overflow), .underflow(underflow)
  );
  Stack #(.DATA_W(DW), .DEPTH(DP)) u_stack (
    .clk(clk), .write(stack_write), .read(stack_read), .data_in(stack_data_in), .data_out(stack_data_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Redirect monitor: every pulse must match the oldest expected value and cycle
  always @(negedge clk) begin
    if (rst_n) begin
      vec++;
      if (stack_write && stack_read) begin
        errs++;
        $display("FAIL strobe_overlap: write=%b read=%b, required not both high", stack_write, stack_read);
      end
      if (next_pc_valid) begin
        vec++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL spurious_redirect: next_pc=%h at cycle %0d, required no pulse", next_pc, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (next_pc !== e.v || cyc != e.c) begin
            errs++;
            $display("FAIL redirect: next_pc=%h cycle=%0d, required %h cycle=%0d", next_pc, cyc, e.v, e.c);
          end
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_call(input logic [DW-1:0] p, input logic [DW-1:0] t, input bit push);
    pc = p;
    target = t;
    call = 1'b1;
    if (push) sb.push_back('{t, cyc + 1});
    tick();
    call = 1'b0;
  endtask
  task automatic drive_ret(input bit push, input logic [DW-1:0] v);
    ret = 1'b1;
    if (push) sb.push_back('{v, cyc + 3});
    tick();
    ret = 1'b0;
  endtask
  task automatic settle;
    int n;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    tick();
    vec++;
    if (busy || sb.size() != 0) begin
      errs++;
      $display("FAIL settle: busy=%b pending=%0d, required busy=0 pending=0", busy, sb.size());
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    vec++;
    if ({busy, next_pc_valid, stack_write, stack_read, overflow, underflow} !== 6'b0 ||
        next_pc !== '0 || stack_data_in !== '0 || depth !== '0) begin
      errs++;
      $display("FAIL reset: flags=%b next_pc=%h sdi=%h depth=%0d, required all 0",
               {busy, next_pc_valid, stack_write, stack_read, overflow, underflow}, next_pc, stack_data_in, depth);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask
  task automatic test_call;
    drive_call(32'h100, 32'h400, 1);
    vec++;
    if (stack_write !== 1'b1 || stack_data_in !== 32'h101 || next_pc !== 32'h400 || next_pc_valid !== 1'b1 || depth !== 1) begin
      errs++;
      $display("FAIL call: sw=%b sdi=%h npc=%h npv=%b depth=%0d, required 1 101 400 1 1",
               stack_write, stack_data_in, next_pc, next_pc_valid, depth);
    end
    tick();
    vec++;
    if (stack_write !== 1'b0 || next_pc_valid !== 1'b0) begin
      errs++;
      $display("FAIL call_width: sw=%b npv=%b, required 0 0", stack_write, next_pc_valid);
    end
    drive_ret(1, 32'h101);
    settle();
  endtask
  task automatic test_nested;
    logic [DW-1:0] ra [3];
    ra = '{32'h301, 32'h201, 32'h101};
    drive_call(32'h100, 32'h1000, 1);
    drive_call(32'h200, 32'h2000, 1);
    drive_call(32'h300, 32'h3000, 1);
    vec++;
    if (depth !== 3) begin
      errs++;
      $display("FAIL nested_depth: depth=%0d, required 3", depth);
    end
    for (int i = 0; i < 3; i++) begin
      drive_ret(1, ra[i]);
      vec++;
      if (busy !== 1'b1 || stack_read !== 1'b1 || depth !== CW'(2 - i)) begin
        errs++;
        $display("FAIL ret_req%0d: busy=%b sr=%b depth=%0d, required 1 1 %0d", i, busy, stack_read, depth, 2 - i);
      end
      if (i == 1) begin
        call = 1'b1;
        ret = 1'b1;
      end
      tick();
      call = 1'b0;
      ret = 1'b0;
      vec++;
      if (busy !== 1'b1 || stack_read !== 1'b0 || stack_write !== 1'b0 || depth !== CW'(2 - i)) begin
        errs++;
        $display("FAIL ret_wait%0d: busy=%b sr=%b sw=%b depth=%0d, required 1 0 0 %0d",
                 i, busy, stack_read, stack_write, depth, 2 - i);
      end
      tick();
      vec++;
      if (busy !== 1'b0 || next_pc_valid !== 1'b1 || next_pc !== ra[i]) begin
        errs++;
        $display("FAIL ret_done%0d: busy=%b npv=%b npc=%h, required 0 1 %h", i, busy, next_pc_valid, next_pc, ra[i]);
      end
    end
    settle();
    vec++;
    if (depth !== 0) begin
      errs++;
      $display("FAIL nested_end_depth: depth=%0d, required 0", depth);
    end
  endtask
  task automatic test_underflow;
    drive_ret(0, '0);
    vec++;
    if (stack_read !== 1'b0 || next_pc_valid !== 1'b0 || busy !== 1'b0 || underflow !== 1'b1) begin
      errs++;
      $display("FAIL underflow: sr=%b npv=%b busy=%b unf=%b, required 0 0 0 1", stack_read, next_pc_valid, busy, underflow);
    end
    repeat (10) tick();
    vec++;
    if (underflow !== 1'b1 || depth !== 0) begin
      errs++;
      $display("FAIL underflow_sticky: unf=%b depth=%0d, required 1 0", underflow, depth);
    end
  endtask
  task automatic test_overflow;
    for (int i = 0; i < DP; i++) drive_call(32'h1000 + DW'(i), 32'h8000 + DW'(i), 1);
    vec++;
    if (depth !== CW'(DP) || overflow !== 1'b0) begin
      errs++;
      $display("FAIL full: depth=%0d ovf=%b, required %0d 0", depth, overflow, DP);
    end
    drive_call(32'h5555, 32'h6666, 0);
    vec++;
    if (stack_write !== 1'b0 || next_pc_valid !== 1'b0 || depth !== CW'(DP) || overflow !== 1'b1) begin
      errs++;
      $display("FAIL overflow: sw=%b npv=%b depth=%0d ovf=%b, required 0 0 %0d 1",
               stack_write, next_pc_valid, depth, overflow, DP);
    end
    for (int i = DP - 1; i >= 0; i--) begin
      drive_ret(1, 32'h1001 + DW'(i));
      settle();
    end
    vec++;
    if (depth !== 0 || overflow !== 1'b1) begin
      errs++;
      $display("FAIL overflow_drain: depth=%0d ovf=%b, required 0 1", depth, overflow);
    end
  endtask
  task automatic test_simultaneous;
    drive_call(32'h500, 32'h550, 1);
    pc = 32'h600;
    target = 32'h700;
    call = 1'b1;
    ret = 1'b1;
    sb.push_back('{32'h700, cyc + 1});
    tick();
    call = 1'b0;
    ret = 1'b0;
    vec++;
    if (stack_write !== 1'b1 || stack_read !== 1'b0 || depth !== 2 || busy !== 1'b0 || stack_data_in !== 32'h601) begin
      errs++;
      $display("FAIL simultaneous: sw=%b sr=%b depth=%0d busy=%b sdi=%h, required 1 0 2 0 601",
               stack_write, stack_read, depth, busy, stack_data_in);
    end
    drive_ret(1, 32'h601);
    settle();
    drive_ret(1, 32'h501);
    settle();
  endtask
  task automatic test_reset_mid_pop;
    drive_call(32'h900, 32'h950, 1);
    drive_ret(0, '0);
    tick();
    vec++;
    if (busy !== 1'b1 || stack_read !== 1'b0) begin
      errs++;
      $display("FAIL pop_wait: busy=%b sr=%b, required 1 0", busy, stack_read);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({busy, next_pc_valid, stack_write, stack_read, overflow, underflow} !== 6'b0 || depth !== '0 || next_pc !== '0) begin
      errs++;
      $display("FAIL reset_mid_pop: flags=%b depth=%0d npc=%h, required 0 0 0",
               {busy, next_pc_valid, stack_write, stack_read, overflow, underflow}, depth, next_pc);
    end
    tick();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++;
      if (next_pc_valid !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL post_reset%0d: npv=%b busy=%b, required 0 0", i, next_pc_valid, busy);
      end
    end
    drive_call(32'hFFFF_FFFF, 32'h20, 1);
    vec++;
    if (stack_write !== 1'b1 || stack_data_in !== 32'h0 || depth !== 1) begin
      errs++;
      $display("FAIL pc_wrap: sw=%b sdi=%h depth=%0d, required 1 00000000 1", stack_write, stack_data_in, depth);
    end
    drive_ret(1, 32'h0);
    settle();
  endtask
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_call();
    test_nested();
    test_underflow();
    test_overflow();
    test_simultaneous();
    test_reset_mid_pop();
    repeat (3) tick();
    vec++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_left: pending=%0d, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
